// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the Fibonacci/Lucas term generator
package fib_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  localparam logic MODE_FIB   = 1'b0;
  localparam logic MODE_LUCAS = 1'b1;
  localparam logic [1:0] FIB_SEED0 = 2'd0;
  localparam logic [1:0] FIB_SEED1 = 2'd1;
  localparam logic [1:0] LUC_SEED0 = 2'd2;
  localparam logic [1:0] LUC_SEED1 = 2'd1;
  function automatic logic [1:0] seed0(input logic mode);
    return mode == MODE_LUCAS ? LUC_SEED0 : FIB_SEED0;
  endfunction
  function automatic logic [1:0] seed1(input logic mode);
    return mode == MODE_LUCAS ? LUC_SEED1 : FIB_SEED1;
  endfunction
endpackage

// File: rtl/fib_seq_gen_if.sv
// fib_seq_gen_if: request/result handshake bundle of the term generator
interface fib_seq_gen_if #(parameter int WIDTH = 16, parameter int N_WIDTH = 5);
  logic [N_WIDTH-1:0] N;
  logic               mode;
  logic               N_valid;
  logic               N_ready;
  logic [WIDTH-1:0]   Q1;
  logic [WIDTH-1:0]   Fibo_out;
  logic               Fibo_valid;
  logic               Fibo_ovf;
  modport master (output N, mode, N_valid, input N_ready, Q1, Fibo_out, Fibo_valid, Fibo_ovf);
  modport slave  (input N, mode, N_valid, output N_ready, Q1, Fibo_out, Fibo_valid, Fibo_ovf);
endinterface

// File: rtl/fib_step_dp.sv
// fib_step_dp: one combinational recurrence step with sticky overflow tracking
module fib_step_dp #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ovf_a,
  input  logic             ovf_b,
  output logic [WIDTH-1:0] a_n,
  output logic [WIDTH-1:0] b_n,
  output logic             ovf_a_n,
  output logic             ovf_b_n
);
  logic c;
  assign {c, b_n} = {1'b0, a} + {1'b0, b};
  assign a_n = b;
  assign ovf_a_n = ovf_b;
  assign ovf_b_n = ovf_a | ovf_b | c;
endmodule

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: iterative Nth-term Fibonacci/Lucas generator, one term per clock
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int N_WIDTH = 5
) (
  input logic clk,
  input logic reset,
  fib_seq_gen_if.slave bus
);
  state_t             state;
  logic [WIDTH-1:0]   a, b, a_n, b_n, fibo_out;
  logic               ovf_a, ovf_b, ovf_a_n, ovf_b_n, fibo_valid, fibo_ovf;
  logic [N_WIDTH-1:0] cnt;
  fib_step_dp #(.WIDTH(WIDTH)) u_step (
    .a(a), .b(b), .ovf_a(ovf_a), .ovf_b(ovf_b),
    .a_n(a_n), .b_n(b_n), .ovf_a_n(ovf_a_n), .ovf_b_n(ovf_b_n)
  );
  assign bus.N_ready    = (state == IDLE) && !reset;
  assign bus.Q1         = a;
  assign bus.Fibo_out   = fibo_out;
  assign bus.Fibo_valid = fibo_valid;
  assign bus.Fibo_ovf   = fibo_ovf;
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      cnt        <= '0;
      ovf_a      <= 1'b0;
      ovf_b      <= 1'b0;
      fibo_out   <= '0;
      fibo_valid <= 1'b0;
      fibo_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.N_valid) begin
          a     <= WIDTH'(seed0(bus.mode));
          b     <= WIDTH'(seed1(bus.mode));
          cnt   <= bus.N;
          ovf_a <= 1'b0;
          ovf_b <= 1'b0;
          state <= CALC;
        end
        CALC: if (cnt != '0) begin
          a     <= a_n;
          b     <= b_n;
          ovf_a <= ovf_a_n;
          ovf_b <= ovf_b_n;
          cnt   <= cnt - 1'b1;
        end else begin
          // a holds the requested term; b is only look-ahead and its wrap is ignored
          fibo_out   <= a;
          fibo_ovf   <= ovf_a;
          fibo_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          fibo_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fib_seq_gen.sv
// tb_fib_seq_gen: directed scoreboard bench for 16-bit and 8-bit generator instances
module tb_fib_seq_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fib_seq_gen_if #(.WIDTH(16), .N_WIDTH(5)) b16();
  fib_seq_gen_if #(.WIDTH(8), .N_WIDTH(4)) b8();
  fib_seq_gen #(.WIDTH(16), .N_WIDTH(5)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  fib_seq_gen #(.WIDTH(8), .N_WIDTH(4)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  typedef struct {
    logic [15:0] out;
    logic        ovf;
    int          due;
  } exp_t;
  exp_t q16[$], q8[$];
  exp_t e16, e8;
  int vecs = 0, errs = 0, cyc = 0, acc16 = 0, e0 = 0;
  function automatic logic [63:0] term(input int n, input logic m);
    logic [63:0] x, y, t;
    x = m ? 64'd2 : 64'd0;
    y = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  function automatic exp_t mk(input int n, input logic m, input int w, input int due);
    exp_t r;
    logic [63:0] v, lim;
    v = term(n, m);
    lim = 64'd1 << w;
    r.out = 16'(v % lim);
    r.ovf = v >= lim;
    r.due = due;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q16.delete();
      q8.delete();
    end else begin
      if (b16.N_valid && b16.N_ready) begin
        q16.push_back(mk(int'(b16.N), b16.mode, 16, cyc + int'(b16.N) + 1));
        acc16 = cyc;
      end
      if (b8.N_valid && b8.N_ready)
        q8.push_back(mk(int'(b8.N), b8.mode, 8, cyc + int'(b8.N) + 1));
    end
  end
  always @(negedge clk) begin
    if (b16.Fibo_valid) begin
      if (q16.size() == 0) chk("spurious16", 1, 0);
      else begin
        e16 = q16.pop_front();
        chk("out16", b16.Fibo_out, e16.out);
        chk("ovf16", b16.Fibo_ovf, e16.ovf);
        chk("lat16", cyc, e16.due);
      end
    end
    if (b8.Fibo_valid) begin
      if (q8.size() == 0) chk("spurious8", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("out8", b8.Fibo_out, e8.out);
        chk("ovf8", b8.Fibo_ovf, e8.ovf);
        chk("lat8", cyc, e8.due);
      end
    end
  end
  task automatic send16(input int n, input logic m);
    @(negedge clk);
    b16.N = 5'(n);
    b16.mode = m;
    b16.N_valid = 1'b1;
    @(negedge clk);
    b16.N_valid = 1'b0;
  endtask
  task automatic send8(input int n, input logic m);
    @(negedge clk);
    b8.N = 4'(n);
    b8.mode = m;
    b8.N_valid = 1'b1;
    @(negedge clk);
    b8.N_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((q16.size() != 0 || q8.size() != 0 || !b16.N_ready || !b8.N_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("idle_timeout", 32'(k >= 200), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    b16.N = '0; b16.mode = 1'b0; b16.N_valid = 1'b0;
    b8.N = '0; b8.mode = 1'b0; b8.N_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_q1", b16.Q1, 0);
    chk("rst_out", b16.Fibo_out, 0);
    chk("rst_valid", b16.Fibo_valid, 0);
    chk("rst_ovf", b16.Fibo_ovf, 0);
    chk("rst_ready", b16.N_ready, 1);
    chk("rst_q1_8", b8.Q1, 0);
    chk("rst_out_8", b8.Fibo_out, 0);
    chk("rst_ready_8", b8.N_ready, 1);
    @(negedge clk);
    b16.N = 5'd6; b16.mode = 1'b0; b16.N_valid = 1'b1;
    @(posedge clk);
    #1;
    b16.N_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("q1_seq", b16.Q1, 32'(term(k, 1'b0)));
      @(posedge clk);
      #1;
    end
    wait_idle();
    chk("fib6", b16.Fibo_out, 8);
    send16(5, 1'b1); wait_idle(); chk("luc5", b16.Fibo_out, 11);
    send16(0, 1'b1); wait_idle(); chk("luc0", b16.Fibo_out, 2);
    send16(0, 1'b0); wait_idle(); chk("fib0", b16.Fibo_out, 0);
    send16(24, 1'b0); wait_idle(); chk("fib24", b16.Fibo_out, 46368); chk("fib24_ovf", b16.Fibo_ovf, 0);
    send16(25, 1'b0); wait_idle(); chk("fib25", b16.Fibo_out, 9489); chk("fib25_ovf", b16.Fibo_ovf, 1);
    send16(31, 1'b1); wait_idle();
    send8(13, 1'b0); wait_idle(); chk("w8_fib13", b8.Fibo_out, 233); chk("w8_ovf13", b8.Fibo_ovf, 0);
    send8(14, 1'b0); wait_idle(); chk("w8_fib14", b8.Fibo_out, 121); chk("w8_ovf14", b8.Fibo_ovf, 1);
    send8(15, 1'b1); wait_idle();
    @(negedge clk);
    b16.N = 5'd5; b16.mode = 1'b0; b16.N_valid = 1'b1;
    @(posedge clk);
    #1;
    e0 = acc16;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("busy_ready", b16.N_ready, 0);
      if (k == 3) b16.N = 5'd3;
    end
    @(negedge clk);
    chk("ready_again", b16.N_ready, 1);
    @(posedge clk);
    #1;
    chk("reaccept_gap", acc16 - e0, 8);
    b16.N_valid = 1'b0;
    wait_idle();
    chk("held_n3", b16.Fibo_out, 2);
    send16(20, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_out", b16.Fibo_out, 0);
    chk("abort_valid", b16.Fibo_valid, 0);
    chk("abort_ready", b16.N_ready, 1);
    repeat (30) @(negedge clk);
    send16(6, 1'b0); wait_idle(); chk("post_abort", b16.Fibo_out, 8);
    chk("queue_drained", q16.size() + q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
